ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (operands, destination register, valid). It accepts one M-extension operation at a time and holds the pipeline through its `stall_req` output, which pipeline control folds into the stall vector so ID/EX holds its contents. Each operation runs a 32-iteration radix-2 shift-add multiply or restoring divide. Divide-by-zero and signed overflow short-circuit to a 1-cycle result.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  ID/EX holds a valid M-extension instruction
- ex_md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- ex_DataA  in  32  rs1 operand
- ex_DataB  in  32  rs2 operand
- ex_rd  in  5  destination register
- flush  in  1  kill the in-flight operation (branch or exception)
- stall_req  out  1  hold the pipeline; combinational
- md_done  out  1  one-cycle pulse: result valid
- md_result  out  32  result; held until the next md_done
- md_rd  out  5  destination of md_result; held with it

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- IDLE, on ex_valid & ~flush (accept):
  - Latch the op, rd, operand magnitudes, and result sign.
  - Signedness of operands: DIV/REM/MULH treat both operands as signed; MULHSU treats A as signed and B as unsigned; all others are unsigned.
  - Divide with B==0: go directly to DONE. Quotient = 0xFFFFFFFF; remainder = A.
  - DIV/REM with A==0x80000000 and B==0xFFFFFFFF: go directly to DONE. Quotient = 0x80000000; remainder = 0.
  - Otherwise go to BUSY with count = 0.
- BUSY: one iteration per cycle.
  - Multiply: 64-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring divide; shift the remainder left, trial subtract, shift in the quotient bit.
  - After iteration 31, apply two's-complement sign correction.
    - Product sign = sign(A) ^ sign(B), signed operands only.
    - Quotient sign = sign(A) ^ sign(B).
    - Remainder sign = sign(A).
  - Write md_result/md_rd and go to DONE.
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: md_done = 1. Go to IDLE unconditionally; never re-accept in DONE.
- stall_req = rst_n & ~flush & ex_valid & (state != DONE).
- flush in any state: go to IDLE next cycle. No md_done; md_result/md_rd are unchanged.
- Reset values: state IDLE, count 0, md_done 0, md_result 0, md_rd 0. stall_req is 0 while rst_n is low.

## Timing
- The accept cycle is T0. BUSY occupies T1..T32. DONE is T33.
  - stall_req is high T0..T32 and low at T33, so ID/EX advances on the T33 edge.
  - md_done and md_result are visible during T33. Latency from accept is 33 cycles.
- Special cases (div-by-zero, overflow): DONE at T1. stall_req is high only in T0.
- Back-to-back operations: a new ex_valid arriving in the cycle after DONE is accepted in IDLE at T34. There is no bubble beyond the DONE cycle.
- ex_valid dropping during BUSY does not abort; only flush or rst_n does. In that case stall_req is 0 (ex_valid gated) and the result still completes.
- Reset mid-operation: on the next edge return to the reset values. Any partial result is discarded.
- flush coinciding with iteration 31 or with DONE:
  - flush wins.
  - In DONE, the pulse is already asserted this cycle; pipeline control ignores it under flush.
- count is 5 bits. The terminal iteration is detected at count==31; count never wraps.

## Test plan
- MUL, A=7, B=0xFFFFFFFD (-3), rd=5 -> stall_req high 33 cycles; at T33 md_done=1, md_result=0xFFFFFFEB, md_rd=5.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- Divides with A=0xFFFFFFF9 (-7), B=2:
  - DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
  - DIVU -> 0x7FFFFFFC; REMU -> 1.
- Corner cases, each done at T1 with stall_req high one cycle:
  - DIVU 123/0 -> 0xFFFFFFFF.
  - REMU 123/0 -> 123.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Flush and reset mid-operation:
  - flush at BUSY count 10 -> state IDLE next cycle, no md_done, md_result keeps its old value. A following MUL 3×4 completes with 12.
  - rst_n low mid-BUSY -> all outputs 0, and no md_done afterwards.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Uses a radix-2 shift-add multiply and a restoring divide, one bit per cycle.
module ex_muldiv #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [2:0]      ex_md_op,
  input  logic [XLEN-1:0] ex_DataA,
  input  logic [XLEN-1:0] ex_DataB,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            stall_req,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_rd
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } md_op_e;

  state_e          state;
  logic [4:0]      count;
  md_op_e          op;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] acc_hi, acc_lo, mag_b;
  logic            neg_a, neg_b;

  md_op_e          in_op;
  logic            in_sa, in_sb, div_zero, div_ovf;
  logic [XLEN-1:0] in_mag_a, in_mag_b;

  assign in_op = md_op_e'(ex_md_op);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    in_sa    = 1'b0;
    in_sb    = 1'b0;
    div_zero = 1'b0;
    div_ovf  = 1'b0;
    case (in_op)
      OP_MULH, OP_DIV, OP_REM: begin
        in_sa = ex_DataA[XLEN-1];
        in_sb = ex_DataB[XLEN-1];
      end
      OP_MULHSU: in_sa = ex_DataA[XLEN-1];
      default: ;
    endcase
    in_mag_a = in_sa ? -ex_DataA : ex_DataA;
    in_mag_b = in_sb ? -ex_DataB : ex_DataB;
    div_zero = in_op[2] && (ex_DataB == '0);
    div_ovf  = (in_op == OP_DIV || in_op == OP_REM) &&
               (ex_DataA == {1'b1, {(XLEN-1){1'b0}}}) && (ex_DataB == '1);
  end

  // One iteration step; acc_hi is the product high half or the running remainder.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   nxt_hi, nxt_lo, quot, rem, result;
  logic [2*XLEN-1:0] product;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    if (op[2]) begin
      if (div_shift >= {1'b0, mag_b}) begin
        nxt_hi = div_diff[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    product = {nxt_hi, nxt_lo};
    if (neg_a ^ neg_b) product = -product;
    quot = nxt_lo;
    if (neg_a ^ neg_b) quot = -quot;
    rem = nxt_hi;
    if (neg_a) rem = -rem;
    case (op)
      OP_MUL:                       result = product[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = product[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quot;
      default:                      result = rem;
    endcase
  end

  assign stall_req = rst_n & ~flush & ex_valid & (state != S_DONE);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= '0;
      md_done   <= 1'b0;
      md_result <= '0;
      md_rd     <= '0;
      op        <= OP_MUL;
      rd_q      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      mag_b     <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
    end else begin
      md_done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        count <= '0;
      end else begin
        case (state)
          S_IDLE: if (ex_valid) begin
            op   <= in_op;
            rd_q <= ex_rd;
            if (div_zero) begin
              // REM/REMU have funct3[1] set: remainder is A, quotient is all ones.
              md_result <= in_op[1] ? ex_DataA : '1;
              md_rd     <= ex_rd;
              md_done   <= 1'b1;
              state     <= S_DONE;
            end else if (div_ovf) begin
              md_result <= in_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              md_rd     <= ex_rd;
              md_done   <= 1'b1;
              state     <= S_DONE;
            end else begin
              acc_hi <= '0;
              acc_lo <= in_mag_a;
              mag_b  <= in_mag_b;
              neg_a  <= in_sa;
              neg_b  <= in_sb;
              count  <= '0;
              state  <= S_BUSY;
            end
          end
          S_BUSY: begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            if (count == 5'd31) begin
              md_result <= result;
              md_rd     <= rd_q;
              md_done   <= 1'b1;
              count     <= '0;
              state     <= S_DONE;
            end else begin
              count <= count + 5'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: table of directed vectors plus
// hand-written flush, valid-drop and reset sequences.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [2:0]  ex_md_op;
  logic [31:0] ex_DataA, ex_DataB;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        stall_req, md_done;
  logic [31:0] md_result;
  logic [4:0]  md_rd;

  int checks = 0;
  int errors = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_md_op(ex_md_op),
    .ex_DataA(ex_DataA), .ex_DataB(ex_DataB), .ex_rd(ex_rd), .flush(flush),
    .stall_req(stall_req), .md_done(md_done), .md_result(md_result), .md_rd(md_rd)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Starts at a point where the DUT is idle; returns one cycle after DONE.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input bit hold, input string tag);
    int n;
    int stalls;
    bit done;
    ex_md_op = op; ex_DataA = a; ex_DataB = b; ex_rd = rd; ex_valid = 1'b1;
    #1;
    stalls = int'(stall_req);
    done = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (!hold) ex_valid = 1'b0;
      #1;
      n++;
      if (md_done) done = 1'b1;
      else stalls += int'(stall_req);
    end
    check({tag, " done seen"}, 32'(done), 32'd1);
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, md_result, exp);
    check({tag, " rd"}, 32'(md_rd), 32'(rd));
    check({tag, " stall at done"}, 32'(stall_req), 32'd0);
    check({tag, " stall cycles"}, stalls, hold ? lat : 1);
    ex_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit saw_done;

    vecs[0]  = '{MUL,    32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33};
    vecs[1]  = '{MULH,   32'h80000000,   32'h80000000, 5'd1,  32'h40000000, 33};
    vecs[2]  = '{MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF,   32'd2,        5'd3,  32'hFFFFFFFF, 33};
    vecs[4]  = '{DIV,    32'hFFFFFFF9,   32'd2,        5'd4,  32'hFFFFFFFD, 33};
    vecs[5]  = '{REM,    32'hFFFFFFF9,   32'd2,        5'd6,  32'hFFFFFFFF, 33};
    vecs[6]  = '{DIVU,   32'hFFFFFFF9,   32'd2,        5'd8,  32'h7FFFFFFC, 33};
    vecs[7]  = '{REMU,   32'hFFFFFFF9,   32'd2,        5'd10, 32'h00000001, 33};
    vecs[8]  = '{DIV,    32'd100,        32'hFFFFFFF9, 5'd11, 32'hFFFFFFF2, 33};
    vecs[9]  = '{REM,    32'd100,        32'hFFFFFFF9, 5'd12, 32'h00000002, 33};
    vecs[10] = '{MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 5'd13, 32'h00000000, 33};
    vecs[11] = '{DIVU,   32'd123,        32'd0,        5'd14, 32'hFFFFFFFF, 1};
    vecs[12] = '{REMU,   32'd123,        32'd0,        5'd15, 32'd123,      1};
    vecs[13] = '{DIV,    32'h80000000,   32'hFFFFFFFF, 5'd16, 32'h80000000, 1};
    vecs[14] = '{REM,    32'h80000000,   32'hFFFFFFFF, 5'd17, 32'h00000000, 1};

    rst_n = 1'b0; ex_valid = 1'b1; flush = 1'b0;
    ex_md_op = MUL; ex_DataA = '0; ex_DataB = '0; ex_rd = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset stall_req", 32'(stall_req), 32'd0);
    check("reset md_done", 32'(md_done), 32'd0);
    check("reset md_result", md_result, 32'd0);
    check("reset md_rd", 32'(md_rd), 32'd0);
    ex_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each op is presented the cycle after the previous DONE.
    for (int i = 0; i < 15; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat, 1'b1,
             $sformatf("vec%0d", i));

    // Flush at BUSY count 10: no result, outputs keep the last value.
    ex_md_op = MUL; ex_DataA = 32'd5; ex_DataB = 32'd6; ex_rd = 5'd20; ex_valid = 1'b1;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush10 stall_req", 32'(stall_req), 32'd0);
    @(negedge clk);
    flush = 1'b0; ex_valid = 1'b0;
    #1;
    check("flush10 md_done", 32'(md_done), 32'd0);
    check("flush10 md_result held", md_result, 32'h00000000);
    check("flush10 md_rd held", 32'(md_rd), 32'd17);
    run_op(MUL, 32'd3, 32'd4, 5'd7, 32'd12, 33, 1'b1, "after flush");

    // Flush coinciding with iteration 31 wins over completion.
    ex_md_op = DIVU; ex_DataA = 32'd100; ex_DataB = 32'd7; ex_rd = 5'd9; ex_valid = 1'b1;
    repeat (32) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush31 md_done", 32'(md_done), 32'd0);
    @(negedge clk);
    flush = 1'b0; ex_valid = 1'b0;
    #1;
    check("flush31 no done", 32'(md_done), 32'd0);
    check("flush31 md_result held", md_result, 32'd12);
    check("flush31 md_rd held", 32'(md_rd), 32'd7);

    // ex_valid dropped during BUSY: stall falls, the result still completes.
    run_op(DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 33, 1'b0, "valid drop");

    // Reset mid-BUSY discards the operation.
    ex_md_op = DIV; ex_DataA = 32'd1000; ex_DataB = 32'd3; ex_rd = 5'd21; ex_valid = 1'b1;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst stall_req", 32'(stall_req), 32'd0);
    @(negedge clk);
    #1;
    check("midrst md_done", 32'(md_done), 32'd0);
    check("midrst md_result", md_result, 32'd0);
    check("midrst md_rd", 32'(md_rd), 32'd0);
    rst_n = 1'b1; ex_valid = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_done |= md_done;
    end
    check("midrst no later done", 32'(saw_done), 32'd0);
    run_op(REMU, 32'd1000, 32'd3, 5'd22, 32'd1, 33, 1'b1, "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
